cva6_cfg_dump: RTL

- Runtime reader for the elaborated core configuration (config_pkg::cva6_user_cfg_t).
- Flattens the static configuration into a read-only table of 64-bit discovery words: header, feature/size word, then (base, length) pairs for the non-idempotent, execute and cached region rules.
- Two access paths to the table: a random-access req/gnt/rvalid port for debug-module/CSR-shim reads, and a valid/ready stream that dumps every word in order, for trace/boot logging.

---
 rtl/cva6_cfg_dump.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/cva6_cfg_dump.sv
// Runtime reader for the elaborated CVA6 configuration: a flat table of 64-bit
// discovery words with a random-access read port and an ordered dump stream.

package config_pkg;

   typedef struct packed {
      int unsigned XLEN;
      bit          RVF;
      bit          RVD;
      bit          RVA;
      bit          RVB;
      bit          RVC;
      bit          RVV;
      bit          RVH;
      bit          RVZCB;
      bit          RVZCMP;
      bit          RVZiCond;
      bit          CvxifEn;
      bit          MmuPresent;
      bit          DebugEn;
      bit          PerfCounterEn;
      bit          RVS;
      bit          RVU;
      int unsigned NrPMPEntries;
      int unsigned NrScoreboardEntries;
      int unsigned NrCommitPorts;
      int unsigned NrNonIdempotentRules;
      bit [1023:0] NonIdempotentAddrBase;
      bit [1023:0] NonIdempotentLength;
      int unsigned NrExecuteRegionRules;
      bit [1023:0] ExecuteRegionAddrBase;
      bit [1023:0] ExecuteRegionLength;
      int unsigned NrCachedRegionRules;
      bit [1023:0] CachedRegionAddrBase;
      bit [1023:0] CachedRegionLength;
   } cva6_user_cfg_t;

   // 64-bit Sv39 application-class core; rule i occupies bits [64*i +: 64].
   localparam cva6_user_cfg_t cva6_cfg_default = '{
      XLEN:                  64,
      RVF:                   1'b1,
      RVD:                   1'b1,
      RVA:                   1'b1,
      RVB:                   1'b1,
      RVC:                   1'b1,
      RVV:                   1'b0,
      RVH:                   1'b0,
      RVZCB:                 1'b1,
      RVZCMP:                1'b0,
      RVZiCond:              1'b1,
      CvxifEn:               1'b1,
      MmuPresent:            1'b1,
      DebugEn:               1'b1,
      PerfCounterEn:         1'b1,
      RVS:                   1'b1,
      RVU:                   1'b1,
      NrPMPEntries:          8,
      NrScoreboardEntries:   8,
      NrCommitPorts:         2,
      NrNonIdempotentRules:  2,
      NonIdempotentAddrBase: 1024'({64'h0000_0000_1000_0000, 64'h0000_0000_0000_0000}),
      NonIdempotentLength:   1024'({64'h0000_0000_1000_0000, 64'h0000_0000_0000_1000}),
      NrExecuteRegionRules:  2,
      ExecuteRegionAddrBase: 1024'({64'h0000_0000_0001_0000, 64'h0000_0000_0000_0000}),
      ExecuteRegionLength:   1024'({64'h0000_0000_0001_0000, 64'h0000_0000_0000_1000}),
      NrCachedRegionRules:   2,
      CachedRegionAddrBase:  1024'({64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000}),
      CachedRegionLength:    1024'({64'h0000_0000_4000_0000, 64'h0000_0000_4000_0000})
   };

endpackage

module cva6_cfg_dump #(
   parameter config_pkg::cva6_user_cfg_t CVA6Cfg  = config_pkg::cva6_cfg_default,
   parameter int unsigned                IdxWidth = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic [IdxWidth-1:0] addr_i,
   output logic                gnt_o,
   output logic                rvalid_o,
   output logic [63:0]         rdata_o,
   output logic                err_o,
   input  logic                dump_start_i,
   input  logic                dump_abort_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [63:0]         out_data_o,
   output logic                out_last_o,
   output logic                done_o
);

   localparam int unsigned NumNi    = CVA6Cfg.NrNonIdempotentRules;
   localparam int unsigned NumEx    = CVA6Cfg.NrExecuteRegionRules;
   localparam int unsigned NumCa    = CVA6Cfg.NrCachedRegionRules;
   localparam int unsigned NumWords = 2 + 2 * (NumNi + NumEx + NumCa);
   localparam int unsigned ExOffset = 2 + 2 * NumNi;
   localparam int unsigned CaOffset = ExOffset + 2 * NumEx;

   localparam logic [IdxWidth-1:0] LastIdx     = IdxWidth'(NumWords - 1);
   localparam logic                FirstIsLast = (NumWords == 1);

   typedef enum logic {
      IDLE,
      STREAM
   } state_e;

   state_e              state;
   logic [IdxWidth-1:0] idx;
   logic [IdxWidth-1:0] nxt_idx;
   logic [63:0]         table_w [NumWords];
   logic [63:0]         rd_word;
   logic [63:0]         nxt_word;
   logic                addr_in_range;

   always_comb begin
      for (int unsigned k = 0; k < NumWords; k++) begin
         table_w[k] = '0;
      end
      table_w[0] = {32'hCA6C_F600, 16'h0000, 8'h01, 8'(NumWords)};
      table_w[1] = {16'h0000,
                    8'(CVA6Cfg.NrCommitPorts),
                    8'(CVA6Cfg.XLEN),
                    8'(CVA6Cfg.NrScoreboardEntries),
                    8'(CVA6Cfg.NrPMPEntries),
                    CVA6Cfg.RVU, CVA6Cfg.RVS, CVA6Cfg.PerfCounterEn, CVA6Cfg.DebugEn,
                    CVA6Cfg.MmuPresent, CVA6Cfg.CvxifEn, CVA6Cfg.RVZiCond, CVA6Cfg.RVZCMP,
                    CVA6Cfg.RVZCB, CVA6Cfg.RVH, CVA6Cfg.RVV, CVA6Cfg.RVC,
                    CVA6Cfg.RVB, CVA6Cfg.RVA, CVA6Cfg.RVD, CVA6Cfg.RVF};
      for (int unsigned i = 0; i < NumNi; i++) begin
         table_w[2 + 2*i]        = CVA6Cfg.NonIdempotentAddrBase[64*i +: 64];
         table_w[3 + 2*i]        = CVA6Cfg.NonIdempotentLength[64*i +: 64];
      end
      for (int unsigned i = 0; i < NumEx; i++) begin
         table_w[ExOffset + 2*i]     = CVA6Cfg.ExecuteRegionAddrBase[64*i +: 64];
         table_w[ExOffset + 2*i + 1] = CVA6Cfg.ExecuteRegionLength[64*i +: 64];
      end
      for (int unsigned i = 0; i < NumCa; i++) begin
         table_w[CaOffset + 2*i]     = CVA6Cfg.CachedRegionAddrBase[64*i +: 64];
         table_w[CaOffset + 2*i + 1] = CVA6Cfg.CachedRegionLength[64*i +: 64];
      end
   end

   assign nxt_idx       = idx + IdxWidth'(1);
   assign addr_in_range = (32'(addr_i) < NumWords);

   // Compare-based lookup keeps out-of-range indices from selecting past the table.
   always_comb begin
      rd_word  = '0;
      nxt_word = '0;
      for (int unsigned k = 0; k < NumWords; k++) begin
         if (addr_i == IdxWidth'(k)) rd_word = table_w[k];
         if (nxt_idx == IdxWidth'(k)) nxt_word = table_w[k];
      end
   end

   assign gnt_o = req_i && (state == IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid_o <= 1'b0;
         rdata_o  <= '0;
         err_o    <= 1'b0;
      end else begin
         rvalid_o <= gnt_o;
         if (gnt_o) begin
            rdata_o <= addr_in_range ? rd_word : '0;
            err_o   <= !addr_in_range;
         end else begin
            rdata_o <= '0;
            err_o   <= 1'b0;
         end
      end
   end

   // out_valid_o is high for the whole of STREAM, so a handshake reduces to out_ready_i.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         idx         <= '0;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_last_o  <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (dump_start_i) begin
                  state       <= STREAM;
                  idx         <= '0;
                  out_valid_o <= 1'b1;
                  out_data_o  <= table_w[0];
                  out_last_o  <= FirstIsLast;
               end
            end
            STREAM: begin
               if (dump_abort_i) begin
                  state       <= IDLE;
                  idx         <= '0;
                  out_valid_o <= 1'b0;
                  out_data_o  <= '0;
                  out_last_o  <= 1'b0;
               end else if (out_ready_i) begin
                  if (out_last_o) begin
                     state       <= IDLE;
                     idx         <= '0;
                     out_valid_o <= 1'b0;
                     out_data_o  <= '0;
                     out_last_o  <= 1'b0;
                     done_o      <= 1'b1;
                  end else begin
                     idx        <= nxt_idx;
                     out_data_o <= nxt_word;
                     out_last_o <= (nxt_idx == LastIdx);
                  end
               end
            end
         endcase
      end
   end

endmodule
